// File: rtl/half_subtractor.sv
// Single-bit half subtractor: combinational X-Y with a registered
// side-path (result copy, valid strobe, saturating borrow counter).
module half_subtractor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             X,
    input  logic             Y,
    input  logic             en,
    output logic             diff,
    output logic             bout,
    output logic             diff_q,
    output logic             bout_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] borrow_cnt
);

    logic             diff_d;
    logic             bout_d;
    logic             valid_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat;

    // Zero-latency result, independent of clock, reset and enable
    assign diff = X ^ Y;
    assign bout = ~X & Y;

    assign cnt_sat = &cnt_q;

    // Next-state: capture on enable, count borrows without wrapping
    always_comb begin
        diff_d  = diff_q;
        bout_d  = bout_q;
        valid_d = en;
        cnt_d   = cnt_q;
        if (en) begin
            diff_d = diff;
            bout_d = bout;
            if (bout && !cnt_sat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared immediately when reset asserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q  <= 1'b0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor: directed phases plus
// random traffic against an arithmetic reference model.
module tb_half_subtractor;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             X;
    logic             Y;
    logic             en;
    logic             diff;
    logic             bout;
    logic             diff_q;
    logic             bout_q;
    logic             valid_q;
    logic [CNT_W-1:0] borrow_cnt;

    bit clk_run;
    int tests;
    int fails;

    // reference model state
    int m_diff;
    int m_bout;
    int m_valid;
    int m_cnt;

    half_subtractor #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .X          (X),
        .Y          (Y),
        .en         (en),
        .diff       (diff),
        .bout       (bout),
        .diff_q     (diff_q),
        .bout_q     (bout_q),
        .valid_q    (valid_q),
        .borrow_cnt (borrow_cnt)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        int d;
        d = int'(X) - int'(Y);
        check("diff", 32'(diff), 32'(d != 0));
        check("bout", 32'(bout), 32'(d < 0));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".diff_q"}, 32'(diff_q), 32'(m_diff));
        check({tag, ".bout_q"}, 32'(bout_q), 32'(m_bout));
        check({tag, ".valid_q"}, 32'(valid_q), 32'(m_valid));
        check({tag, ".cnt"}, 32'(borrow_cnt), 32'(m_cnt));
    endtask

    task automatic model_clear();
        m_diff  = 0;
        m_bout  = 0;
        m_valid = 0;
        m_cnt   = 0;
    endtask

    // drive at negedge, step one edge, check away from the edge
    task automatic cycle(input logic x, input logic y,
                         input logic e, input string tag);
        int d;
        X  = x;
        Y  = y;
        en = e;
        #1 check_comb();
        d = int'(x) - int'(y);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (e) begin
                m_diff = (d != 0) ? 1 : 0;
                m_bout = (d < 0) ? 1 : 0;
                if (d < 0 && m_cnt < MAXC) m_cnt = m_cnt + 1;
            end
            m_valid = e ? 1 : 0;
        end
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        logic [1:0] tt [4];
        tests   = 0;
        fails   = 0;
        clk     = 1'b0;
        clk_run = 1'b0;
        rst_n   = 1'b0;
        X       = 1'b0;
        Y       = 1'b0;
        en      = 1'b0;
        model_clear();

        // truth table with clock idle and reset asserted
        tt[0] = 2'b00;
        tt[1] = 2'b10;
        tt[2] = 2'b01;
        tt[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            X = tt[i][1];
            Y = tt[i][0];
            #10 check_comb();
        end
        check_regs("rst_idle");

        // start clock, release reset
        clk_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_regs("after_rel");

        // latency and hold
        cycle(1'b0, 1'b1, 1'b1, "lat");
        cycle(1'b1, 1'b1, 1'b0, "hold");

        // counter saturation
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b1, "sat");
        check("sat_max", 32'(borrow_cnt), 32'(MAXC));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, "noborrow");
        check("sat_keep", 32'(borrow_cnt), 32'(MAXC));

        // counter gating by en
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, "gate");

        // random traffic
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        // async reset mid-run
        @(negedge clk);
        rst_n = 1'b0;
        #1 model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, "pre5");
        check("pre5_cnt", 32'(borrow_cnt), 32'd5);
        check("pre5_diff", 32'(diff_q), 32'd1);
        #2 rst_n = 1'b0;
        #1 model_clear();
        check_regs("async_clr");
        X = 1'b1;
        Y = 1'b0;
        #1 check_comb();
        X = 1'b0;
        Y = 1'b1;
        #1 check_comb();
        @(negedge clk);
        check_regs("in_rst");
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, "post_rel");
        cycle(1'b0, 1'b1, 1'b1, "post_rel2");
        check("post_cnt", 32'(borrow_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
